pkt_sf_fifo: RTL and testbench

//  Parametrised store-and-forward packet FIFO: a packet becomes readable only once its last beat is

---
 rtl/pkt_sf_fifo_if.sv | 38 +++
 rtl/pkt_sf_fifo.sv | 117 +++++++++++
 tb/tb_pkt_sf_fifo.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_sf_fifo_if.sv
// Producer/consumer bundle for pkt_sf_fifo. The fifo takes the slave modport.
// With PKT_SF_FIFO_STATS_EN defined the bundle also carries the two packet statistics counters.
interface pkt_sf_fifo_if #(
  parameter int DEPTH_LG2  = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  wvalid_i;
  logic                  wready_o;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  wlast_i;
  logic                  werr_i;
  logic                  rvalid_o;
  logic                  rready_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  rlast_o;
  logic [DEPTH_LG2:0]    pkt_cnt_o;
  logic                  drop_o;
`ifdef PKT_SF_FIFO_STATS_EN
  logic [31:0]           stat_cmt_o;
  logic [31:0]           stat_drop_o;
`endif

  modport master (
    output wvalid_i, wdata_i, wlast_i, werr_i, rready_i,
    input  wready_o, rvalid_o, rdata_o, rlast_o, pkt_cnt_o, drop_o
`ifdef PKT_SF_FIFO_STATS_EN
    , input stat_cmt_o, stat_drop_o
`endif
  );

  modport slave (
    input  wvalid_i, wdata_i, wlast_i, werr_i, rready_i,
    output wready_o, rvalid_o, rdata_o, rlast_o, pkt_cnt_o, drop_o
`ifdef PKT_SF_FIFO_STATS_EN
    , output stat_cmt_o, stat_drop_o
`endif
  );
endinterface

// File: rtl/pkt_sf_fifo.sv
// Store-and-forward packet FIFO. A packet becomes readable only after its last beat is written without error.
// Errored or oversize packets are discarded by rewinding the write pointer. PKT_SF_FIFO_STATS_EN adds commit/drop counters.
module pkt_sf_fifo #(
  parameter int DEPTH_LG2  = 4,
  parameter int DATA_WIDTH = 32,
  parameter bit RST_MEM    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  pkt_sf_fifo_if.slave     bus
);
  localparam int DEPTH = 1 << DEPTH_LG2;
  localparam int PW    = DEPTH_LG2 + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

  state_t              state;
  logic [PW-1:0]       wr_tmp, wr_cmt, rd, pkt_cnt;
  logic                drop;
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic full, wready, rvalid, rlast, w_acc, r_acc, store, commit, err_drop, overflow, last_read;

  // Everything here comes from registered state only, so no output depends combinationally on an input.
  assign full      = (wr_tmp[DEPTH_LG2] != rd[DEPTH_LG2]) &&
                     (wr_tmp[DEPTH_LG2-1:0] == rd[DEPTH_LG2-1:0]);
  assign wready    = (state == DROP) ? 1'b1 : !full;
  assign rvalid    = (rd != wr_cmt);
  assign rlast     = rvalid && mem[rd[DEPTH_LG2-1:0]][DATA_WIDTH];
  assign w_acc     = bus.wvalid_i && wready;
  assign r_acc     = rvalid && bus.rready_i;
  assign store     = w_acc && (state != DROP);
  assign commit    = store && bus.wlast_i && !bus.werr_i;
  assign err_drop  = store && bus.wlast_i && bus.werr_i;
  // Overflow: the whole FIFO is a single uncommitted packet, so it can never finish and must be dropped.
  assign overflow  = (state == FILL) && full && (wr_cmt == rd) && bus.wvalid_i;
  assign last_read = r_acc && rlast;

  assign bus.wready_o  = wready;
  assign bus.rvalid_o  = rvalid;
  assign bus.rdata_o   = mem[rd[DEPTH_LG2-1:0]][DATA_WIDTH-1:0];
  assign bus.rlast_o   = rlast;
  assign bus.pkt_cnt_o = pkt_cnt;
  assign bus.drop_o    = drop;

  // NOTE: sequential state uses non-blocking assignments, so every block sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_tmp  <= '0;
      wr_cmt  <= '0;
      rd      <= '0;
      pkt_cnt <= '0;
      drop    <= 1'b0;
    end else begin
      drop <= err_drop || overflow;
      if (r_acc) rd <= rd + PTR_ONE;

      if (overflow) begin
        wr_tmp <= wr_cmt;
        state  <= DROP;
      end else if (store) begin
        if (!bus.wlast_i) begin
          wr_tmp <= wr_tmp + PTR_ONE;
          state  <= FILL;
        end else if (bus.werr_i) begin
          wr_tmp <= wr_cmt;
          state  <= IDLE;
        end else begin
          wr_tmp <= wr_tmp + PTR_ONE;
          wr_cmt <= wr_tmp + PTR_ONE;
          state  <= IDLE;
        end
      end else if (state == DROP && bus.wvalid_i && bus.wlast_i) begin
        state <= IDLE;
      end

      if (commit && !last_read)      pkt_cnt <= pkt_cnt + PTR_ONE;
      else if (last_read && !commit) pkt_cnt <= pkt_cnt - PTR_ONE;
    end
  end

  // NOTE: storage is kept out of the control reset so it can map to plain RAM unless RST_MEM asks otherwise.
  generate
    if (RST_MEM) begin : g_mem_rst
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (store) begin
          mem[wr_tmp[DEPTH_LG2-1:0]] <= {bus.wlast_i, bus.wdata_i};
        end
      end
    end else begin : g_mem_norst
      always_ff @(posedge clk) begin
        if (store) mem[wr_tmp[DEPTH_LG2-1:0]] <= {bus.wlast_i, bus.wdata_i};
      end
    end
  endgenerate

`ifdef PKT_SF_FIFO_STATS_EN
  logic [31:0] stat_cmt, stat_drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cmt  <= '0;
      stat_drop <= '0;
    end else begin
      if (commit && stat_cmt != '1)                    stat_cmt  <= stat_cmt + 32'd1;
      if ((err_drop || overflow) && stat_drop != '1)   stat_drop <= stat_drop + 32'd1;
    end
  end

  assign bus.stat_cmt_o  = stat_cmt;
  assign bus.stat_drop_o = stat_drop;
`endif
endmodule

// File: tb/tb_pkt_sf_fifo.sv
// Directed bench for pkt_sf_fifo (DEPTH_LG2=4, DATA_WIDTH=32): a vector table for the basic and
// errored-packet flows, then hand-written sequences for overflow, stall, commit/read overlap and reset.
module tb_pkt_sf_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pkt_sf_fifo_if #(.DEPTH_LG2(4), .DATA_WIDTH(32)) bus ();
  pkt_sf_fifo #(.DEPTH_LG2(4), .DATA_WIDTH(32), .RST_MEM(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        wvalid;
    logic [31:0] wdata;
    logic        wlast;
    logic        werr;
    logic        rready;
    logic        e_wready;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic        e_rlast;
    logic [4:0]  e_pkt;
    logic        e_drop;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int drop_seen = 0;
  int drop_at = 0;
  int cur_beat = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; drop pulses are tallied here.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.drop_o) begin
      drop_seen++;
      drop_at = cur_beat;
    end
  endtask

  task automatic idle_inputs();
    bus.wvalid_i = 1'b0;
    bus.wdata_i  = '0;
    bus.wlast_i  = 1'b0;
    bus.werr_i   = 1'b0;
    bus.rready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    drop_seen = 0;
  endtask

  task automatic send_beat(input logic [31:0] data, input logic last, input logic err);
    int budget;
    bus.wvalid_i = 1'b1;
    bus.wdata_i  = data;
    bus.wlast_i  = last;
    bus.werr_i   = err;
    budget = 0;
    while (!bus.wready_o && budget < 50) begin
      step();
      budget++;
    end
    if (!bus.wready_o) check("wready_timeout", 64'(bus.wready_o), 64'd1);
    step();
    bus.wvalid_i = 1'b0;
    bus.wlast_i  = 1'b0;
    bus.werr_i   = 1'b0;
  endtask

  task automatic read_beat(input string name, input logic [31:0] data, input logic last);
    int budget;
    bus.rready_i = 1'b1;
    budget = 0;
    while (!bus.rvalid_o && budget < 50) begin
      step();
      budget++;
    end
    check({name, "_rvalid"}, 64'(bus.rvalid_o), 64'd1);
    check({name, "_rdata"},  64'(bus.rdata_o),  64'(data));
    check({name, "_rlast"},  64'(bus.rlast_o),  64'(last));
    step();
    bus.rready_i = 1'b0;
  endtask

  vec_t vecs [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //             wv  wdata     wl    we    rr    wr    rv    rdata     rl    pkt   drop
    vecs[0]  = '{1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};
    vecs[1]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};
    vecs[2]  = '{1'b1, 32'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b0, 5'd1, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b0, 5'd1, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA2, 1'b1, 5'd1, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};
    vecs[7]  = '{1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};
    vecs[8]  = '{1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};
    vecs[9]  = '{1'b1, 32'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};
    vecs[10] = '{1'b1, 32'hB3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b1};
    vecs[12] = '{1'b1, 32'hC0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};
    vecs[13] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hC0, 1'b1, 5'd1, 1'b0};
    vecs[14] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};

    do_reset();
    check("rst_wready",  64'(bus.wready_o),  64'd1);
    check("rst_rvalid",  64'(bus.rvalid_o),  64'd0);
    check("rst_rlast",   64'(bus.rlast_o),   64'd0);
    check("rst_pkt_cnt", 64'(bus.pkt_cnt_o), 64'd0);
    check("rst_drop",    64'(bus.drop_o),    64'd0);

    // Good 3-beat packet, read back, then an errored 4-beat packet and a 1-beat follow-up.
    for (int i = 0; i < 15; i++) begin
      bus.wvalid_i = vecs[i].wvalid;
      bus.wdata_i  = vecs[i].wdata;
      bus.wlast_i  = vecs[i].wlast;
      bus.werr_i   = vecs[i].werr;
      bus.rready_i = vecs[i].rready;
      check($sformatf("vec%0d_wready", i),  64'(bus.wready_o),  64'(vecs[i].e_wready));
      check($sformatf("vec%0d_rvalid", i),  64'(bus.rvalid_o),  64'(vecs[i].e_rvalid));
      check($sformatf("vec%0d_pkt_cnt", i), 64'(bus.pkt_cnt_o), 64'(vecs[i].e_pkt));
      check($sformatf("vec%0d_drop", i),    64'(bus.drop_o),    64'(vecs[i].e_drop));
      if (vecs[i].e_rvalid) begin
        check($sformatf("vec%0d_rdata", i), 64'(bus.rdata_o), 64'(vecs[i].e_rdata));
        check($sformatf("vec%0d_rlast", i), 64'(bus.rlast_o), 64'(vecs[i].e_rlast));
      end
      step();
    end
    idle_inputs();

    // Oversize: a 20-beat packet into an empty FIFO is dropped when beat 17 finds it full.
    do_reset();
    for (int b = 1; b <= 20; b++) begin
      cur_beat = b;
      send_beat(32'h1000 + 32'(b), b == 20, 1'b0);
    end
    cur_beat = 0;
    check("ovf_drop_count", 64'(drop_seen), 64'd1);
    check("ovf_drop_beat",  64'(drop_at),   64'd17);
    check("ovf_pkt_cnt",    64'(bus.pkt_cnt_o), 64'd0);
    check("ovf_rvalid",     64'(bus.rvalid_o),  64'd0);
    send_beat(32'h100, 1'b0, 1'b0);
    send_beat(32'h101, 1'b1, 1'b0);
    check("ovf_next_rvalid", 64'(bus.rvalid_o),  64'd1);
    check("ovf_next_pkt",    64'(bus.pkt_cnt_o), 64'd1);
    read_beat("ovf_next0", 32'h100, 1'b0);
    read_beat("ovf_next1", 32'h101, 1'b1);
    check("ovf_next_pkt_end", 64'(bus.pkt_cnt_o), 64'd0);

    // Stall: committed data present when full, so the writer waits instead of dropping.
    do_reset();
    send_beat(32'hD0, 1'b0, 1'b0);
    send_beat(32'hD1, 1'b1, 1'b0);
    for (int b = 1; b <= 14; b++) send_beat(32'h2000 + 32'(b), 1'b0, 1'b0);
    bus.wvalid_i = 1'b1;
    bus.wdata_i  = 32'h200F;
    bus.wlast_i  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d_wready", k), 64'(bus.wready_o), 64'd0);
      step();
    end
    check("stall_no_drop", 64'(drop_seen), 64'd0);
    bus.rready_i = 1'b1;
    check("stall_rd_d0", 64'(bus.rdata_o), 64'hD0);
    step();
    bus.rready_i = 1'b0;
    check("stall_release_wready", 64'(bus.wready_o), 64'd1);
    step();
    idle_inputs();
    check("stall_pkt_cnt", 64'(bus.pkt_cnt_o), 64'd2);
    check("stall_no_drop_end", 64'(drop_seen), 64'd0);
    read_beat("stall_d1", 32'hD1, 1'b1);
    for (int b = 1; b <= 15; b++) read_beat($sformatf("stall_b%0d", b), 32'h2000 + 32'(b), b == 15);
    check("stall_pkt_cnt_end", 64'(bus.pkt_cnt_o), 64'd0);

    // Commit of a 1-beat packet on the same edge as the previous packet's last read.
    do_reset();
    send_beat(32'hE0, 1'b0, 1'b0);
    send_beat(32'hE1, 1'b1, 1'b0);
    read_beat("ovl_e0", 32'hE0, 1'b0);
    bus.wvalid_i = 1'b1;
    bus.wdata_i  = 32'hF0;
    bus.wlast_i  = 1'b1;
    bus.rready_i = 1'b1;
    check("ovl_e1_rdata", 64'(bus.rdata_o),   64'hE1);
    check("ovl_e1_rlast", 64'(bus.rlast_o),   64'd1);
    check("ovl_pkt_pre",  64'(bus.pkt_cnt_o), 64'd1);
    step();
    idle_inputs();
    check("ovl_pkt_post", 64'(bus.pkt_cnt_o), 64'd1);
    read_beat("ovl_f0", 32'hF0, 1'b1);
    check("ovl_pkt_end",  64'(bus.pkt_cnt_o), 64'd0);

    // Reset while a packet is filling, with a committed packet already resident.
    do_reset();
    send_beat(32'h30, 1'b1, 1'b0);
    send_beat(32'h31, 1'b1, 1'b1);
`ifdef PKT_SF_FIFO_STATS_EN
    check("stat_cmt_pre",  64'(bus.stat_cmt_o),  64'd1);
    check("stat_drop_pre", 64'(bus.stat_drop_o), 64'd1);
`endif
    for (int b = 0; b < 5; b++) send_beat(32'h40 + 32'(b), 1'b0, 1'b0);
    check("mid_pkt_cnt", 64'(bus.pkt_cnt_o), 64'd1);
    idle_inputs();
    rst_n = 1'b0;
    step();
    check("mrst_rvalid",  64'(bus.rvalid_o),  64'd0);
    check("mrst_pkt_cnt", 64'(bus.pkt_cnt_o), 64'd0);
    check("mrst_wready",  64'(bus.wready_o),  64'd1);
`ifdef PKT_SF_FIFO_STATS_EN
    check("mrst_stat_cmt",  64'(bus.stat_cmt_o),  64'd0);
    check("mrst_stat_drop", 64'(bus.stat_drop_o), 64'd0);
`endif
    rst_n = 1'b1;
    step();
    send_beat(32'h50, 1'b0, 1'b0);
    send_beat(32'h51, 1'b1, 1'b0);
    read_beat("post_rst0", 32'h50, 1'b0);
    read_beat("post_rst1", 32'h51, 1'b1);
    check("post_rst_pkt", 64'(bus.pkt_cnt_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
